// File: rtl/serial_sub_pkg.sv
// serial_sub_pkg: FSM state type and counter sizing for serial_subtractor
package serial_sub_pkg;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  function automatic int cnt_w(input int n);
    return $clog2(n);
  endfunction
endpackage

// File: rtl/full_adder.sv
// full_adder: one-bit full adder cell
module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic co,
  output logic sum
);
  assign sum = a ^ b ^ ci;
  assign co  = (a & b) | (ci & (a ^ b));
endmodule

// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial d = a - b - bin through one full_adder, LSB first
// SERIAL_SUB_OVF_EN adds the registered signed-overflow output ovf
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         bin,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] d,
  output logic         bout
`ifdef SERIAL_SUB_OVF_EN
  ,output logic        ovf
`endif
);
  localparam int CW = cnt_w(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);
  state_t        state;
  logic [N-1:0]  sa, sb;
  logic          c, co, s;
  logic [CW-1:0] cnt;
  full_adder u_fa (.a(sa[0]), .b(sb[0]), .ci(c), .co(co), .sum(s));
  assign in_ready  = state == IDLE;
  assign out_valid = state == DONE;
  // subtraction as a + ~b + ~bin; borrow-out is the inverted final carry
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      sa    <= '0;
      sb    <= '0;
      c     <= 1'b0;
      cnt   <= '0;
      d     <= '0;
      bout  <= 1'b0;
    end else if (state == IDLE && in_valid) begin
      sa    <= a;
      sb    <= ~b;
      c     <= ~bin;
      cnt   <= '0;
      state <= BUSY;
    end else if (state == BUSY) begin
      sa  <= sa >> 1;
      sb  <= sb >> 1;
      d   <= {s, d[N-1:1]};
      c   <= co;
      cnt <= cnt + CW'(1);
      if (cnt == LAST) begin
        bout  <= ~co;
        state <= DONE;
      end
    end else if (state == DONE && out_ready) begin
      state <= IDLE;
    end
  end
`ifdef SERIAL_SUB_OVF_EN
  // on the MSB edge c still holds the carry into the MSB
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ovf <= 1'b0;
    else if (state == BUSY && cnt == LAST) ovf <= c ^ co;
  end
`endif
endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: directed checks of serial_subtractor with N=8
module tb_serial_subtractor;
  localparam int N = 8;
  logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b0, bin = 1'b0;
  logic [N-1:0] a = '0, b = '0;
  logic in_ready, out_valid, bout;
  logic [N-1:0] d;
  int errs = 0, checks = 0;
`ifdef SERIAL_SUB_OVF_EN
  logic ovf;
`endif

  serial_subtractor #(.N(N)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .bin(bin), .out_valid(out_valid), .out_ready(out_ready),
    .d(d), .bout(bout)
`ifdef SERIAL_SUB_OVF_EN
    , .ovf(ovf)
`endif
  );

  always #5 clk = ~clk;

  task automatic start_op(input logic [N-1:0] ta, input logic [N-1:0] tb, input logic tbin);
    @(negedge clk);
    a = ta; b = tb; bin = tbin; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = ~ta; b = ~tb; bin = ~tbin;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #12;
    checks++; if (in_ready !== 1'b1) begin errs++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errs++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
    checks++; if (d !== 8'h00) begin errs++; $display("FAIL reset_d got %h exp 00", d); end
    checks++; if (bout !== 1'b0) begin errs++; $display("FAIL reset_bout got %b exp 0", bout); end
`ifdef SERIAL_SUB_OVF_EN
    checks++; if (ovf !== 1'b0) begin errs++; $display("FAIL reset_ovf got %b exp 0", ovf); end
`endif
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_vectors;
    logic [N-1:0] va [5] = '{8'h05, 8'h03, 8'h80, 8'h00, 8'h7F};
    logic [N-1:0] vb [5] = '{8'h03, 8'h05, 8'h01, 8'h00, 8'hFF};
    logic         vi [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [N-1:0] vd [5] = '{8'h02, 8'hFE, 8'h7F, 8'hFF, 8'h80};
    logic         vo [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
`ifdef SERIAL_SUB_OVF_EN
    logic         vv [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
`endif
    for (int i = 0; i < 5; i++) begin
      start_op(va[i], vb[i], vi[i]);
      checks++; if (in_ready !== 1'b0) begin errs++; $display("FAIL vec%0d_busy_in_ready got %b exp 0", i, in_ready); end
      repeat (N - 1) @(posedge clk);
      #1;
      checks++; if (out_valid !== 1'b0) begin errs++; $display("FAIL vec%0d_early_valid got %b exp 0", i, out_valid); end
      @(posedge clk); #1;
      checks++; if (out_valid !== 1'b1) begin errs++; $display("FAIL vec%0d_valid got %b exp 1", i, out_valid); end
      checks++; if (d !== vd[i]) begin errs++; $display("FAIL vec%0d_d got %h exp %h", i, d, vd[i]); end
      checks++; if (bout !== vo[i]) begin errs++; $display("FAIL vec%0d_bout got %b exp %b", i, bout, vo[i]); end
`ifdef SERIAL_SUB_OVF_EN
      checks++; if (ovf !== vv[i]) begin errs++; $display("FAIL vec%0d_ovf got %b exp %b", i, ovf, vv[i]); end
`endif
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errs++; $display("FAIL vec%0d_release got rdy=%b vld=%b exp rdy=1 vld=0", i, in_ready, out_valid); end
    end
  endtask

  task automatic test_backpressure;
    start_op(8'h20, 8'h10, 1'b0);
    repeat (N) @(posedge clk);
    @(negedge clk);
    in_valid = 1'b1; a = 8'h01; b = 8'h02; bin = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++; if (out_valid !== 1'b1) begin errs++; $display("FAIL bp%0d_valid got %b exp 1", i, out_valid); end
      checks++; if (d !== 8'h10 || bout !== 1'b0) begin errs++; $display("FAIL bp%0d_data got d=%h bout=%b exp d=10 bout=0", i, d, bout); end
      checks++; if (in_ready !== 1'b0) begin errs++; $display("FAIL bp%0d_in_ready got %b exp 0", i, in_ready); end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errs++; $display("FAIL bp_release got rdy=%b vld=%b exp rdy=1 vld=0", in_ready, out_valid); end
    // the ignored bundle must not have been latched: one idle cycle stays idle
    @(posedge clk); #1;
    checks++; if (in_ready !== 1'b1) begin errs++; $display("FAIL bp_ignored_in got rdy=%b exp 1", in_ready); end
  endtask

  task automatic test_mid_reset;
    out_ready = 1'b1;
    start_op(8'h55, 8'h11, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errs++; $display("FAIL mrst_flags got vld=%b rdy=%b exp vld=0 rdy=1", out_valid, in_ready); end
    checks++; if (d !== 8'h00 || bout !== 1'b0) begin errs++; $display("FAIL mrst_data got d=%h bout=%b exp d=00 bout=0", d, bout); end
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b0;
    for (int i = 0; i < N + 2; i++) begin
      @(posedge clk); #1;
      checks++; if (out_valid !== 1'b0) begin errs++; $display("FAIL mrst_pulse%0d got %b exp 0", i, out_valid); end
    end
    out_ready = 1'b1;
    start_op(8'd10, 8'd4, 1'b0);
    repeat (N - 1) @(posedge clk);
    #1;
    checks++; if (out_valid !== 1'b0) begin errs++; $display("FAIL mrst_early_valid got %b exp 0", out_valid); end
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b1 || d !== 8'h06 || bout !== 1'b0) begin errs++; $display("FAIL mrst_next got vld=%b d=%h bout=%b exp vld=1 d=06 bout=0", out_valid, d, bout); end
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errs++; $display("FAIL mrst_early_ready got rdy=%b vld=%b exp rdy=1 vld=0", in_ready, out_valid); end
  endtask

  initial begin
    test_reset;
    test_vectors;
    test_backpressure;
    test_mid_reset;
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
